light_sequencer: RTL and testbench
==================================

// Module: light_sequencer
// PURPOSE
//  Traffic-light state machine directly downstream of the interval-parameter block.
//  Drives the 2-bit interval select to that block and consumes the 5-bit duration it
//  returns (base, extended or yellow).
//  Counts each phase down and sequences main/side street lamps.
//  Uses the side-road sensor to decide whether a green phase gets the extended interval.
// PARAMETERS
//  TICK_DIV  1  clk cycles per timing tick, >=1 (1 = one tick per clk, for simulation)
// PORTS
//  clk          in   1  system clock, all state on rising edge
//  reset_sync   in   1  asynchronous, active-high reset
//  sensor_sync  in   1  side-road vehicle present, already synchronised
//  value        in   5  duration in ticks from parameter block, valid same cycle as interval
//  interval     out  2  00 base, 01 extended, 10 yellow (11 never driven)
//  main_light   out  3  {R,Y,G} one-hot: 100 red, 010 yellow, 001 green
//  side_light   out  3  {R,Y,G} one-hot, same encoding
//  phase        out  3  current FSM state code, for debug/bench
// BEHAVIOUR
//  States and codes, each with its lamps and interval:
//   MG 0: main G, side R, interval 00
//   MGX 1: main G, side R, interval 01
//   MY 2: main Y, side R, interval 10
//   SG 3: main R, side G, interval 00
//   SGX 4: main R, side G, interval 01
//   SY 5: main R, side Y, interval 10
//  All outputs are registered; lamps and interval change on the same edge as the state.
//  Reset (async, immediate, also mid-phase):
//   - state MG, interval 00, main 001, side 100
//   - cnt 0, load_pend 1, prescaler 0
//  Phase timing:
//   - On the edge entering a state, load_pend<=1.
//   - Next edge: cnt<=value (value 0 loads as 1), load_pend<=0, prescaler<=0.
//   - After that, cnt decrements once per tick; a tick fires when the prescaler reaches TICK_DIV-1.
//   - Tick with cnt==1: move to the next state.
//   - Dwell = 1 + max(value,1)*TICK_DIV cycles.
//  value is sampled only in the load cycle; reprogramming mid-phase affects the next load only.
//  Transitions on expiry; sensor_sync is sampled on the expiry edge only:
//   - MG -> MY if sensor_sync==1, else MG -> MGX
//   - MGX -> MY
//   - MY -> SG
//   - SG -> SGX if sensor_sync==1, else SG -> SY
//   - SGX -> SY
//   - SY -> MG
//  Codes 6/7 (and 7 in flash build) are illegal: recover to MG with load_pend=1 on next edge.
//  cnt is 5 bits and never wraps: the decrement is gated when cnt==0.
// CONFIGURATION
//  LIGHT_SEQ_FLASH_EN defined: adds input flash_sync (1 bit) and state FL (code 6).
//   - flash_sync==1 in any state: next edge enters FL; interval held 10.
//   - In FL: main and side both {0,Y,0}; Y toggles each tick, starting on (010).
//   - flash_sync==0 while in FL: next edge enters SY with load_pend=1 (full yellow, then MG).
//   - flash_sync has priority over expiry on the same edge.
//  LIGHT_SEQ_FLASH_EN undefined: no flash_sync port, no FL state; code 6 is illegal.
// TESTING (TICK_DIV=1, parameter block at reset defaults base 6, ext 3, yellow 2)
//  1 reset, sensor_sync=0 -> MG 7 cycles, MGX 4, MY 3, SG 7, SY 3; period 24 cycles, repeats.
//  2 sensor_sync=1 held -> MG 7, MY 3, SG 7, SGX 4, SY 3; interval 00,10,00,01,10 in order.
//  3 yellow reprogrammed to 0 -> MY and SY each last 2 cycles (value 0 loads as 1).
//  4 base changed 6->9 at cycle 3 of MG -> current MG still 7 cycles; next SG lasts 10.
//  5 reset_sync pulsed mid SGX -> same cycle: main 001, side 100, interval 00, phase 0; MG then 7 cycles.
//  6 [FLASH_EN] flash_sync=1 during SG for 6 cycles -> next edge FL, Y toggles 010/000 each cycle;
//    release -> SY 3 cycles, then MG.

Source files
------------

// File: rtl/light_sequencer.sv
// Two-road traffic-light sequencer; phase durations come from an external parameter block.
// Define LIGHT_SEQ_FLASH_EN to add the flash_sync input and the flashing-yellow FL state.
module light_sequencer #(
    parameter int TICK_DIV = 1
) (
    input  logic       clk,
    input  logic       reset_sync,
    input  logic       sensor_sync,
`ifdef LIGHT_SEQ_FLASH_EN
    input  logic       flash_sync,
`endif
    input  logic [4:0] value,
    output logic [1:0] interval,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic [2:0] phase
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {
        MG  = 3'd0,
        MGX = 3'd1,
        MY  = 3'd2,
        SG  = 3'd3,
        SGX = 3'd4,
        SY  = 3'd5
`ifdef LIGHT_SEQ_FLASH_EN
        , FL = 3'd6
`endif
    } state_t;

    state_t          state, nxt;
    logic [4:0]      cnt;
    logic            load_pend;
    logic [PW-1:0]   prescaler;
    logic            ps_wrap, expire, enter, in_fl;

    function automatic logic [2:0] main_of(input state_t s);
        case (s)
            MG, MGX:     main_of = 3'b001;
            SG, SGX, SY: main_of = 3'b100;
            default:     main_of = 3'b010;
        endcase
    endfunction

    function automatic logic [2:0] side_of(input state_t s);
        case (s)
            MG, MGX, MY: side_of = 3'b100;
            SG, SGX:     side_of = 3'b001;
            default:     side_of = 3'b010;
        endcase
    endfunction

    function automatic logic [1:0] interval_of(input state_t s);
        case (s)
            MG, SG:   interval_of = 2'b00;
            MGX, SGX: interval_of = 2'b01;
            default:  interval_of = 2'b10;
        endcase
    endfunction

`ifdef LIGHT_SEQ_FLASH_EN
    assign in_fl = (state == FL);
`else
    assign in_fl = 1'b0;
`endif

    assign phase = state;

    always_comb begin
        ps_wrap = (prescaler == PW'(TICK_DIV - 1));
        expire  = !load_pend && ps_wrap && (cnt == 5'd1);
        enter   = 1'b0;
        nxt     = MG;
`ifdef LIGHT_SEQ_FLASH_EN
        // Flash request beats a same-edge expiry.
        if (flash_sync) begin
            enter = (state != FL);
            nxt   = FL;
        end else if (state == FL) begin
            enter = 1'b1;
            nxt   = SY;
        end else
`endif
        begin
            case (state)
                MG:  begin enter = expire; nxt = sensor_sync ? MY : MGX; end
                MGX: begin enter = expire; nxt = MY;  end
                MY:  begin enter = expire; nxt = SG;  end
                SG:  begin enter = expire; nxt = sensor_sync ? SGX : SY; end
                SGX: begin enter = expire; nxt = SY;  end
                SY:  begin enter = expire; nxt = MG;  end
                default: begin enter = 1'b1; nxt = MG; end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset_sync) begin
        if (reset_sync) begin
            state      <= MG;
            interval   <= 2'b00;
            main_light <= 3'b001;
            side_light <= 3'b100;
            cnt        <= 5'd0;
            load_pend  <= 1'b1;
            prescaler  <= '0;
        end else if (enter) begin
            state      <= nxt;
            interval   <= interval_of(nxt);
            main_light <= main_of(nxt);
            side_light <= side_of(nxt);
            load_pend  <= 1'b1;
            prescaler  <= '0;
        end else if (in_fl) begin
            // FL has no countdown; the prescaler only paces the yellow blink.
            prescaler <= ps_wrap ? '0 : prescaler + PW'(1);
            if (ps_wrap) begin
                main_light <= main_light ^ 3'b010;
                side_light <= side_light ^ 3'b010;
            end
        end else if (load_pend) begin
            cnt       <= (value == 5'd0) ? 5'd1 : value;
            load_pend <= 1'b0;
            prescaler <= '0;
        end else begin
            prescaler <= ps_wrap ? '0 : prescaler + PW'(1);
            if (ps_wrap && cnt != 5'd0)
                cnt <= cnt - 5'd1;
        end
    end

endmodule

// File: tb/tb_light_sequencer.sv
// Randomized bench for light_sequencer: cycle-level phase model plus directed literal pins.
module tb_light_sequencer;
    localparam int TD = 1;

    logic       clk = 1'b0;
    logic       reset_sync, sensor_sync;
    logic [4:0] value;
    logic [1:0] interval;
    logic [2:0] main_light, side_light, phase;
`ifdef LIGHT_SEQ_FLASH_EN
    logic       flash_sync;
`endif
    logic [4:0] base, ext, yel;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    // parameter block: combinational lookup on the requested interval
    assign value = (interval == 2'b00) ? base : (interval == 2'b01) ? ext : yel;

    light_sequencer #(.TICK_DIV(TD)) dut (
        .clk(clk),
        .reset_sync(reset_sync),
        .sensor_sync(sensor_sync),
`ifdef LIGHT_SEQ_FLASH_EN
        .flash_sync(flash_sync),
`endif
        .value(value),
        .interval(interval),
        .main_light(main_light),
        .side_light(side_light),
        .phase(phase)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: phase, cycles since entry, cycles left ----------
    int m_state = 0, m_age = 0, m_left = 0;
    int exp_main[6] = '{1, 1, 2, 4, 4, 4};
    int exp_side[6] = '{4, 4, 4, 1, 1, 2};
    int exp_int[6]  = '{0, 1, 2, 0, 1, 2};

    function automatic int dur_of(input int s);
        int v;
        case (s)
            0, 3:    v = base;
            1, 4:    v = ext;
            default: v = yel;
        endcase
        return ((v == 0) ? 1 : v) * TD;
    endfunction

    function automatic int next_of(input int s, input bit sen);
        case (s)
            0:       return sen ? 2 : 1;
            1:       return 2;
            2:       return 3;
            3:       return sen ? 4 : 5;
            4:       return 5;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk or posedge reset_sync) begin : model
        int s, a, l;
        if (reset_sync) begin
            m_state <= 0; m_age <= 0; m_left <= 0;
        end else begin
            s = m_state; a = m_age; l = m_left;
`ifdef LIGHT_SEQ_FLASH_EN
            if (flash_sync) begin
                if (s != 6) begin s = 6; a = 0; end
                else a++;
            end else if (s == 6) begin
                s = 5; a = 0;
            end else
`endif
            if (a == 0) begin
                l = dur_of(s); a = 1;
            end else begin
                l--; a++;
                if (l == 0) begin s = next_of(s, sensor_sync); a = 0; end
            end
            m_state <= s; m_age <= a; m_left <= l;
        end
    end

    always @(negedge clk) begin
        chk("phase", phase, m_state);
        if (m_state == 6) begin
            chk("fl_main", main_light, ((m_age / TD) % 2 == 0) ? 2 : 0);
            chk("fl_side", side_light, ((m_age / TD) % 2 == 0) ? 2 : 0);
            chk("fl_interval", interval, 2);
        end else begin
            chk("main_light", main_light, exp_main[m_state]);
            chk("side_light", side_light, exp_side[m_state]);
            chk("interval", interval, exp_int[m_state]);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic check_reset_outputs(input string nm);
        chk({nm, "_main"}, main_light, 3'b001);
        chk({nm, "_side"}, side_light, 3'b100);
        chk({nm, "_interval"}, interval, 2'b00);
        chk({nm, "_phase"}, phase, 0);
    endtask

    task automatic wait_phase(input int p, input string nm);
        int n = 0;
        while (phase != 3'(p) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk(nm, phase, p);
    endtask

    // call right after the edge that entered phase p
    task automatic dwell(input int p, input int exp, input string nm);
        int n = 1;
        forever begin
            @(posedge clk); #1;
            if (phase != 3'(p) || n >= 100) break;
            n++;
        end
        chk(nm, n, exp);
    endtask

    int ek[7] = '{6, 7, 10, 11, 14, 21, 24};
    int ep[7] = '{0, 1, 1, 2, 3, 5, 0};

    initial begin
        reset_sync = 1'b1; sensor_sync = 1'b0;
        base = 5'd6; ext = 5'd3; yel = 5'd2;
`ifdef LIGHT_SEQ_FLASH_EN
        flash_sync = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset_sync = 1'b0;

        // sensor low: MG 7, MGX 4, MY 3, SG 7, SY 3
        begin
            int idx = 0;
            for (int k = 1; k <= 24; k++) begin
                @(posedge clk); #1;
                if (idx < 7 && k == ek[idx]) begin
                    chk("seq_phase", phase, ep[idx]);
                    idx++;
                end
            end
        end

        // sensor high: SG extends into SGX, then reset mid-phase
        sensor_sync = 1'b1;
        wait_phase(4, "reach_sgx");
        chk("sgx_interval", interval, 1);
        @(negedge clk); #2 reset_sync = 1'b1;
        #1 check_reset_outputs("mid_reset");
        @(negedge clk); reset_sync = 1'b0; sensor_sync = 1'b0;
        dwell(0, 7, "mg_after_reset");

        // yellow of 0 still gives one tick
        yel = 5'd0;
        wait_phase(2, "reach_my");
        dwell(2, 2, "my_yellow0");
        yel = 5'd2;
        wait_phase(3, "reach_sg");

`ifdef LIGHT_SEQ_FLASH_EN
        @(negedge clk); flash_sync = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(posedge clk); #1;
            chk("flash_phase", phase, 6);
            chk("flash_main", main_light, (j % 2 == 0) ? 2 : 0);
        end
        @(negedge clk); flash_sync = 1'b0;
        @(posedge clk); #1;
        chk("flash_exit_phase", phase, 5);
        dwell(5, 3, "sy_after_flash");
        chk("mg_after_flash", phase, 0);
`endif

        // randomized traffic, reprogramming and resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(3) == 0) sensor_sync = 1'($urandom_range(1));
            if ($urandom_range(40) == 0) begin
                case ($urandom_range(2))
                    0:       base = 5'($urandom_range(10));
                    1:       ext  = 5'($urandom_range(10));
                    default: yel  = 5'($urandom_range(5));
                endcase
            end
`ifdef LIGHT_SEQ_FLASH_EN
            if (flash_sync) begin
                if ($urandom_range(5) == 0) flash_sync = 1'b0;
            end else if ($urandom_range(150) == 0) flash_sync = 1'b1;
`endif
            if ($urandom_range(500) == 0) begin
                #2 reset_sync = 1'b1;
                #1 check_reset_outputs("rand_reset");
                @(negedge clk); reset_sync = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout reached t=%0t", $time);
        $fatal(1);
    end

endmodule
